qcs_fir_cap_buf: RTL

QCS_FIR_CAP_BUF -- requirements
Module: qcs_fir_cap_buf

---
 rtl/qcs_fir_cap_buf.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/qcs_fir_cap_buf.sv
// Packet capture buffer: admits whole I/Q packets into a show-ahead FIFO only when a full packet fits.
// Optional macro QCS_FIR_CAP_TSTAMP_EN tags every word with the cycle count at its packet start.
module qcs_fir_cap_buf #(
  parameter int DW      = 16,
  parameter int NCH     = 1,
  parameter int PKT_LEN = 64,
  parameter int DEPTH   = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cap_en,
  input  logic                data_vld,
  input  logic [NCH*DW-1:0]   data_i,
  input  logic [NCH*DW-1:0]   data_q,
  input  logic                rd_rdy,
  output logic                rd_vld,
  output logic [NCH*DW-1:0]   rd_data_i,
  output logic [NCH*DW-1:0]   rd_data_q,
  output logic                rd_last,
  output logic [31:0]         rd_tstamp,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  localparam int W  = NCH * DW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(PKT_LEN + 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(PKT_LEN - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_C    = CW'(PKT_LEN);
  localparam bit            SINGLE   = (PKT_LEN == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   smp_cnt, smp_n;

  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            start, room, pop;
  logic            wr_en, wr_last, pkt_inc, drop_inc;

  logic [W-1:0]    mem_i    [DEPTH];
  logic [W-1:0]    mem_q    [DEPTH];
  logic            mem_last [DEPTH];

  // Handshake: a word transfers on any clock edge where rd_vld && rd_rdy;
  // while rd_vld is high and rd_rdy is low all rd_* outputs hold steady.
  assign pop   = rd_vld && rd_rdy;
  assign start = (state == IDLE) && data_vld && cap_en;
  // Space for the whole packet is reserved at its start, so later writes never hit a full FIFO.
  assign room  = (DEPTH_C - count) >= PKT_C;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      smp_cnt <= '0;
    end else begin
      state   <= state_n;
      smp_cnt <= smp_n;
    end
  end

  always_comb begin
    state_n = state;
    smp_n   = smp_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          if (SINGLE) begin
            state_n = IDLE;
            smp_n   = '0;
          end else begin
            state_n = room ? COLLECT : DROP;
            smp_n   = SW'(1);
          end
        end
      end
      COLLECT, DROP: begin
        if (data_vld) begin
          if (smp_cnt == LAST_IDX) begin
            state_n = IDLE;
            smp_n   = '0;
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        smp_n   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    wr_en    = 1'b0;
    wr_last  = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (room) begin
            wr_en   = 1'b1;
            wr_last = SINGLE;
            pkt_inc = SINGLE;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (data_vld) begin
          wr_en   = 1'b1;
          wr_last = (smp_cnt == LAST_IDX);
          pkt_inc = (smp_cnt == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pkt_inc) pkt_cnt <= pkt_cnt + 16'd1;
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_i[wr_ptr]    <= data_i;
      mem_q[wr_ptr]    <= data_q;
      mem_last[wr_ptr] <= wr_last;
    end
  end

  // Show-ahead read: head word is presented combinationally, zeroed while empty.
  assign rd_vld    = (count != '0);
  assign rd_data_i = rd_vld ? mem_i[rd_ptr] : '0;
  assign rd_data_q = rd_vld ? mem_q[rd_ptr] : '0;
  assign rd_last   = rd_vld ? mem_last[rd_ptr] : 1'b0;

`ifdef QCS_FIR_CAP_TSTAMP_EN
  logic [31:0] ts_cnt, pkt_ts, wr_ts;
  logic [31:0] mem_ts [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      pkt_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (start) pkt_ts <= ts_cnt;
    end
  end

  // The only write made from IDLE is the packet-start sample itself.
  assign wr_ts = (state == IDLE) ? ts_cnt : pkt_ts;

  always_ff @(posedge clk) begin
    if (wr_en) mem_ts[wr_ptr] <= wr_ts;
  end

  assign rd_tstamp = rd_vld ? mem_ts[rd_ptr] : '0;
`else
  assign rd_tstamp = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset_n) assert (!(wr_en && (count == DEPTH_C)));
  end

endmodule
